score_display: RTL and testbench
================================

Name: score_display

Overview:
- Downstream consumer of the 11-bit team score produced by the score adder. Drives a 4-digit multiplexed 7-segment display.
- Detects a change in the binary score and converts it to 4-digit BCD with a sequential double-dabble engine, one bit per clock.
- Continuously scans the four digits with leading-zero blanking.
- One instance per team on the scoreboard.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays selected (minimum 2)
BLANK_LEADING, 1, 1 blanks leading zero digits; 0 shows all four digits

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
score  input  11  binary score from adder, 0..2047, may change any cycle
seg  output  7  active-low segments, bit6=g .. bit0=a
an  output  4  active-low digit enables, an[0]=ones .. an[3]=thousands
bcd  output  16  latched BCD of last converted score, [15:12]=thousands
bcd_valid  output  1  one-cycle pulse when bcd updates
busy  output  1  conversion in progress

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is asynchronous and active-low: reset=0 clears all state immediately, regardless of clk.
- Reset values:
  - FSM=IDLE, last_score=0, bcd=16'h0000, bcd_valid=0, busy=0.
  - Scan counter=0, digit index=0, an=4'b1111, seg=7'b1111111.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: at edge k, if score != last_score, capture score into the shift register and last_score, clear the BCD accumulator, set bit count=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: one iteration per edge. First add 3 to each accumulator nibble >= 5, then shift {acc, shreg} left by 1. Runs 11 edges (k+1..k+11), then goes to DONE.
  - DONE: at edge k+12, bcd<=acc, bcd_valid=1 for that single cycle, return to IDLE. Total latency is 12 edges from capture.
  - busy=1 in SHIFT and DONE, 0 in IDLE.
- Score changes during SHIFT/DONE are ignored. On return to IDLE, the last_score comparison re-triggers conversion, so the final stable value is always displayed.
- The score equals last_score after reset (both 0), so no conversion is triggered and the display shows "0".
- Arithmetic: the accumulator is 16 bits; 2047 fits in 4 digits, so there is no overflow. Nibbles >9 are impossible; if decoded, they are driven blank.
- Scan:
  - The counter counts 0..SCAN_DIV-1. On wrap, the digit index increments 0->1->2->3->0.
  - an and seg are registered and reflect the current digit index and bcd one edge later.
- Segment decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i>0 is blanked when nibble i and all higher nibbles are 0.
  - Blanked slot: an=4'b1111, seg=7'b1111111.
  - The ones digit is never blanked.
- Display source: the display always shows the latched bcd, never the in-flight accumulator.
- Reset mid-conversion: FSM aborts, bcd returns to 0, busy drops immediately, and no bcd_valid pulse is emitted.

Test Plan:
- Reset, then release, with score=0 and SCAN_DIV=4:
  - busy stays 0, no bcd_valid, bcd=0000.
  - an=1110 with seg=1000000 during slot 0.
  - an=1111 during slots 1..3.
- Score to 1234 captured at edge k:
  - busy=1 over k+1..k+12.
  - At k+12, bcd=16'h1234 and bcd_valid pulses exactly one cycle.
  - Scan yields an 1110/1101/1011/0111, with seg 0011001/0110000/0100100/1111001.
- Score=2047 (adder wrap value):
  - bcd=16'h2047.
  - Thousands slot seg=0100100, hundreds slot seg=1000000 (not blanked: a higher digit is non-zero).
- Score=7:
  - bcd=16'h0007, slots 1..3 show an=1111, ones slot seg=1111000.
  - Repeat with BLANK_LEADING=0: all four digits lit, seg=1000000 on digits 1..3.
- Score=100, then 205 at k+5:
  - bcd=16'h0100 with a valid pulse at k+12.
  - Second conversion starts at k+13; bcd=16'h0205 at k+25.
  - Exactly two bcd_valid pulses.
- Reset asserted at k+6 during a conversion of 999:
  - Immediately: bcd=0, busy=0, an=1111, seg=1111111.
  - After release, score is still 999: conversion re-runs and bcd=16'h0999.

Source files
------------

// File: rtl/score_display.sv
// score_display
// Per-team scoreboard display driver. Watches the binary team score and
// converts each new value to 4-digit BCD with a sequential double-dabble
// engine (one bit per clock). The latched BCD value is scanned onto a
// 4-digit multiplexed 7-segment display, with optional leading-zero blanking.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   score      11-bit binary score (0..2047), may change on any cycle
//   seg        active-low segments, bit6=g .. bit0=a (registered)
//   an         active-low digit enables, an[0]=ones .. an[3]=thousands (registered)
//   bcd        BCD of the last converted score, [15:12]=thousands
//   bcd_valid  single-cycle pulse when bcd updates
//   busy       high while a conversion is in progress
module score_display #(
  parameter int SCAN_DIV      = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] score,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic        busy
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [10:0]      lastScore_q, lastScore_d;
  logic [10:0]      shreg_q, shreg_d;
  logic [15:0]      acc_q, acc_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             bcdValid_q, bcdValid_d;
  logic [15:0]      adjAcc;

  logic [CNT_W-1:0] scanCnt_q, scanCnt_d;
  logic [1:0]       digitIdx_q, digitIdx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       curNibble;
  logic             blankSlot;

  // Double-dabble correction: any BCD nibble of 5 or more would exceed 9
  // after the next doubling, so bump it by 3 to carry into the next digit.
  function automatic logic [15:0] add3(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < 4; i++) begin
      if (a[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-low gfedcba patterns; non-decimal nibbles are shown blank.
  function automatic logic [6:0] segOf(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Conversion FSM. A capture happens only from IDLE, so a score that moves
  // mid-conversion is picked up by the comparison once the engine is idle
  // again, and the last stable value always ends up displayed.
  always_comb begin
    state_d     = state_q;
    lastScore_d = lastScore_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    bitCnt_d    = bitCnt_q;
    bcd_d       = bcd_q;
    bcdValid_d  = 1'b0;
    adjAcc      = add3(acc_q);
    case (state_q)
      S_IDLE: begin
        if (score != lastScore_q) begin
          shreg_d     = score;
          lastScore_d = score;
          acc_d       = '0;
          bitCnt_d    = '0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {acc_d, shreg_d} = {adjAcc, shreg_q} << 1;
        bitCnt_d         = bitCnt_q + 4'd1;
        if (bitCnt_q == 4'd10) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d      = acc_q;
        bcdValid_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lastScore_q <= '0;
      shreg_q     <= '0;
      acc_q       <= '0;
      bitCnt_q    <= '0;
      bcd_q       <= '0;
      bcdValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastScore_q <= lastScore_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      bitCnt_q    <= bitCnt_d;
      bcd_q       <= bcd_d;
      bcdValid_q  <= bcdValid_d;
    end
  end

  // Digit scan: each digit holds for SCAN_DIV cycles. A digit above the ones
  // place is blanked when it and every more significant digit are zero.
  always_comb begin
    scanCnt_d  = scanCnt_q + CNT_W'(1);
    digitIdx_d = digitIdx_q;
    if (scanCnt_q == CNT_LAST) begin
      scanCnt_d  = '0;
      digitIdx_d = digitIdx_q + 2'd1;
    end
    curNibble = bcd_q[digitIdx_q*4 +: 4];
    case (digitIdx_q)
      2'd1:    blankSlot = BLANK_LEADING && (bcd_q[15:4]  == 12'd0);
      2'd2:    blankSlot = BLANK_LEADING && (bcd_q[15:8]  == 8'd0);
      2'd3:    blankSlot = BLANK_LEADING && (bcd_q[15:12] == 4'd0);
      default: blankSlot = 1'b0;
    endcase
    if (blankSlot) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end else begin
      an_d  = ~(4'b0001 << digitIdx_q);
      seg_d = segOf(curNibble);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scanCnt_q  <= '0;
      digitIdx_q <= '0;
      an_q       <= 4'b1111;
      seg_q      <= 7'b1111111;
    end else begin
      scanCnt_q  <= scanCnt_d;
      digitIdx_q <= digitIdx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcdValid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  logic        clk;
  logic        reset;
  logic [10:0] score;
  logic [6:0]  seg,  seg0;
  logic [3:0]  an,   an0;
  logic [15:0] bcd,  bcd0;
  logic        bcd_valid, bcd_valid0;
  logic        busy, busy0;

  int compared   = 0;
  int mismatched = 0;
  int validCount = 0;

  // Scan-window observations for the blanking DUT (dut) and the all-digit DUT (dut0)
  int         litCnt[4];
  logic [6:0] segSeen[4];
  int         blankCnt;
  int         blankBad;
  int         litCnt0[4];
  logic [6:0] segSeen0[4];

  score_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .score(score), .seg(seg), .an(an),
    .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy)
  );

  score_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut0 (
    .clk(clk), .reset(reset), .score(score), .seg(seg0), .an(an0),
    .bcd(bcd0), .bcd_valid(bcd_valid0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bcd_valid === 1'b1) validCount <= validCount + 1;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // 16 cycles = one full scan period at SCAN_DIV=4, so each slot is seen 4 times
  task automatic scanWindow();
    for (int i = 0; i < 4; i++) begin
      litCnt[i] = 0; segSeen[i] = 7'h00; litCnt0[i] = 0; segSeen0[i] = 7'h00;
    end
    blankCnt = 0;
    blankBad = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin litCnt[0]++; segSeen[0] = seg; end
        4'b1101: begin litCnt[1]++; segSeen[1] = seg; end
        4'b1011: begin litCnt[2]++; segSeen[2] = seg; end
        4'b0111: begin litCnt[3]++; segSeen[3] = seg; end
        4'b1111: begin blankCnt++; if (seg !== 7'b1111111) blankBad++; end
        default: blankBad++;
      endcase
      case (an0)
        4'b1110: begin litCnt0[0]++; segSeen0[0] = seg0; end
        4'b1101: begin litCnt0[1]++; segSeen0[1] = seg0; end
        4'b1011: begin litCnt0[2]++; segSeen0[2] = seg0; end
        4'b0111: begin litCnt0[3]++; segSeen0[3] = seg0; end
        default: ;
      endcase
    end
  endtask

  // Drive a new score just before edge k, then return after edge k+12
  task automatic convertAndCheck(input logic [10:0] val, input logic [15:0] expBcd, input string tag);
    int busyBad;
    int validEarly;
    busyBad = 0;
    validEarly = 0;
    score = val;
    for (int e = 0; e <= 11; e++) begin
      @(negedge clk);
      if (busy !== 1'b1) busyBad++;
      if (bcd_valid !== 1'b0) validEarly++;
    end
    checkVal({tag, "_busy_k..k11"}, busyBad, 0);
    checkVal({tag, "_no_early_valid"}, validEarly, 0);
    @(negedge clk);
    checkVal({tag, "_valid_k12"}, bcd_valid, 1'b1);
    checkVal({tag, "_bcd_k12"}, bcd, expBcd);
    checkVal({tag, "_busy_low_k12"}, busy, 1'b0);
    @(negedge clk);
    checkVal({tag, "_valid_one_cycle"}, bcd_valid, 1'b0);
  endtask

  initial begin : stimulus
    int base;
    int busySeen;
    int gotValid;

    // Reset with score 0
    reset = 1'b0;
    score = 11'd0;
    #23;
    checkVal("rst_bcd", bcd, 16'h0000);
    checkVal("rst_busy", busy, 1'b0);
    checkVal("rst_an", an, 4'b1111);
    checkVal("rst_seg", seg, 7'b1111111);
    checkVal("rst_valid", bcd_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    base = validCount;
    busySeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busySeen++;
    end
    checkVal("idle_busy_never", busySeen, 0);
    checkVal("idle_no_valid", validCount - base, 0);
    checkVal("idle_bcd", bcd, 16'h0000);
    scanWindow();
    checkVal("zero_ones_lit", litCnt[0], 4);
    checkVal("zero_ones_seg", segSeen[0], 7'b1000000);
    checkVal("zero_blank_slots", blankCnt, 12);
    checkVal("zero_blank_seg", blankBad, 0);

    // 1234
    convertAndCheck(11'd1234, 16'h1234, "s1234");
    scanWindow();
    checkVal("s1234_lit0", litCnt[0], 4);
    checkVal("s1234_lit3", litCnt[3], 4);
    checkVal("s1234_seg0", segSeen[0], 7'b0011001);
    checkVal("s1234_seg1", segSeen[1], 7'b0110000);
    checkVal("s1234_seg2", segSeen[2], 7'b0100100);
    checkVal("s1234_seg3", segSeen[3], 7'b1111001);

    // 2047: hundreds digit is zero but must stay lit
    convertAndCheck(11'd2047, 16'h2047, "s2047");
    scanWindow();
    checkVal("s2047_seg3", segSeen[3], 7'b0100100);
    checkVal("s2047_lit2", litCnt[2], 4);
    checkVal("s2047_seg2", segSeen[2], 7'b1000000);
    checkVal("s2047_seg1", segSeen[1], 7'b0011001);
    checkVal("s2047_seg0", segSeen[0], 7'b1111000);

    // 7: leading zeros blanked on dut, shown on dut0
    convertAndCheck(11'd7, 16'h0007, "s7");
    scanWindow();
    checkVal("s7_blank_slots", blankCnt, 12);
    checkVal("s7_blank_seg", blankBad, 0);
    checkVal("s7_seg0", segSeen[0], 7'b1111000);
    checkVal("s7_nb_bcd", bcd0, 16'h0007);
    checkVal("s7_nb_lit1", litCnt0[1], 4);
    checkVal("s7_nb_lit2", litCnt0[2], 4);
    checkVal("s7_nb_lit3", litCnt0[3], 4);
    checkVal("s7_nb_seg1", segSeen0[1], 7'b1000000);
    checkVal("s7_nb_seg2", segSeen0[2], 7'b1000000);
    checkVal("s7_nb_seg3", segSeen0[3], 7'b1000000);
    checkVal("s7_nb_seg0", segSeen0[0], 7'b1111000);

    // 100, then 205 arriving mid-conversion (present at edge k+5)
    base = validCount;
    score = 11'd100;
    waitCycles(5);
    score = 11'd205;
    waitCycles(8);
    checkVal("s100_valid_k12", bcd_valid, 1'b1);
    checkVal("s100_bcd_k12", bcd, 16'h0100);
    @(negedge clk);
    checkVal("s205_busy_k13", busy, 1'b1);
    checkVal("s205_bcd_held", bcd, 16'h0100);
    waitCycles(11);
    checkVal("s205_no_valid_k24", bcd_valid, 1'b0);
    @(negedge clk);
    checkVal("s205_valid_k25", bcd_valid, 1'b1);
    checkVal("s205_bcd_k25", bcd, 16'h0205);
    waitCycles(5);
    checkVal("s100_205_pulses", validCount - base, 2);

    // 999 with reset asserted before edge k+6
    score = 11'd999;
    waitCycles(6);
    reset = 1'b0;
    #1;
    checkVal("abort_bcd", bcd, 16'h0000);
    checkVal("abort_busy", busy, 1'b0);
    checkVal("abort_an", an, 4'b1111);
    checkVal("abort_seg", seg, 7'b1111111);
    checkVal("abort_valid", bcd_valid, 1'b0);
    waitCycles(3);
    reset = 1'b1;
    gotValid = 0;
    for (int i = 0; i < 40 && gotValid == 0; i++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) gotValid = 1;
    end
    checkVal("s999_valid_seen", gotValid, 1);
    checkVal("s999_bcd", bcd, 16'h0999);
    scanWindow();
    checkVal("s999_blank_slots", blankCnt, 4);
    checkVal("s999_seg2", segSeen[2], 7'b0010000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
